row_policy_tracker: RTL and testbench
=====================================

// Module: row_policy_tracker
// PURPOSE
//  Per-bank row-buffer state tracker for the DRAM controller, the multi-bank successor to the open-row policy block.
//  Classifies each incoming request as HIT / EMPTY / CONFLICT against the tracked open row of its bank.
//  Supports selectable OPEN, CLOSE and TIMEOUT page policies and raises auto-precharge requests to the scheduler.
//  Sits between the address mapper (bank group/bank/row fields) and the command scheduler.
// PARAMETERS
//  BG_BITS     2    bank-group index width; NBANK = 2**(BG_BITS+BA_BITS)
//  BA_BITS     2    bank index width within a group
//  ROW_BITS    16   row address width
//  TIMEOUT     64   idle cycles before auto-precharge in TIMEOUT mode (>=1)
//  CNT_BITS    $clog2(TIMEOUT+1)  idle-counter width (derived)
// PORTS
//  CLK          in   1                 clock; all state on rising edge
//  RST          in   1                 synchronous, active-high reset
//  pol_mode     in   2                 policy_t: OPEN=0, CLOSE=1, TIMEOUT=2 (3 treated as OPEN)
//  req_valid    in   1                 lookup request valid
//  req_ready    out  1                 lookup accepted when req_valid&req_ready
//  req_bank     in   BG_BITS+BA_BITS   {bank group, bank} from address mapper
//  req_row      in   ROW_BITS          row from address mapper
//  resp_valid   out  1                 classification valid
//  resp_ready   in   1                 consumer accepts resp
//  resp_type    out  2                 resp_t: HIT=0, EMPTY=1, CONFLICT=2
//  resp_bank    out  BG_BITS+BA_BITS   bank echoed with resp
//  cmd_valid    in   1                 scheduler issued a command this cycle
//  cmd_type     in   3                 cmd_t: ACT, RD, WR, PRE, PREA, REF
//  cmd_bank     in   BG_BITS+BA_BITS   target bank (ignored for PREA/REF)
//  cmd_row      in   ROW_BITS          row for ACT
//  pre_req_valid out 1                 auto-precharge request
//  pre_req_ready in  1                 scheduler accepts pre_req
//  pre_req_bank  out BG_BITS+BA_BITS   bank to precharge
// BEHAVIOUR
//  Reset: all banks closed, rows 0, idle counters 0, expired flags 0, arbiter pointer 0; resp_valid=0, resp_type=0,
//   resp_bank=0, pre_req_valid=0, pre_req_bank=0. req_ready=1 one cycle after RST deasserts. RST mid-transfer drops resp.
//  Per-bank state: open, row[ROW_BITS], idle[CNT_BITS], expired.
//  Command update (cmd_valid): ACT -> open=1,row=cmd_row,idle=0,expired=0; RD/WR -> idle=0 (expired=1 if mode CLOSE);
//   PRE -> open=0,expired=0; PREA/REF -> all banks open=0,expired=0. Command to a closed bank for RD/WR: no state change.
//  Idle counting: open bank with no RD/WR/ACT this cycle -> idle++ saturating at TIMEOUT; in TIMEOUT mode idle==TIMEOUT
//   sets expired. OPEN mode never sets expired; pending expired flags are cleared when mode switches to OPEN.
//  Mode change takes effect the following cycle; counters are not reset.
//  Lookup: 1-entry output register, latency 1. req_ready = !resp_valid | resp_ready.
//   Classification uses post-command state (cmd in same cycle is forwarded): !open->EMPTY; row==req_row->HIT; else CONFLICT.
//   resp held stable while resp_valid & !resp_ready.
//  Auto-precharge: round-robin over expired banks starting after last grant; pre_req_valid/bank registered and held stable
//   until pre_req_ready. After handshake the bank is not re-offered until a PRE/PREA/REF or ACT clears it.
//   A PRE/PREA/REF clearing the offered bank while pending withdraws the request next cycle.
//  Simultaneous ACT and lookup to the same bank: lookup sees the new row. Same-cycle RD and expiry on one bank: RD wins.
// STRUCTURE
//  dram_pkg: policy_t, resp_t, cmd_t enums; NBANK derived localparam helper.
//  One sub-module: rr_arbiter #(N=NBANK) (req vector, grant one-hot, pointer advance on accept).
//  Bank state arrays and classification in this module; no further hierarchy.
// TESTING
//  Reset: RST high 2 cycles -> resp_valid=0, pre_req_valid=0; lookup bank 3 row 0x10 -> EMPTY after 1 cycle.
//  ACT bank 5 row 0x1234, then lookup 0x1234 -> HIT; lookup 0x1235 -> CONFLICT; PRE then lookup -> EMPTY.
//  TIMEOUT=4, mode TIMEOUT: ACT bank 2, idle 4 cycles -> pre_req_valid=1 bank 2; hold until ready; PRE clears it.
//  Mode CLOSE: RD banks 1 and 6 same cycle window -> pre_req grants 1 then 6 (round robin); mode OPEN never requests.
//  Same-cycle ACT bank 0 row 7 + lookup bank 0 row 7 -> HIT; resp_ready low 3 cycles -> resp stable, req_ready=0.
//  PREA with 3 banks open and pre_req pending -> all EMPTY on lookup, pre_req_valid drops next cycle.

Source files
------------

// File: rtl/row_policy_tracker_pkg.sv
// rtl/row_policy_tracker_pkg.sv - shared enums and bank-count helper for the row policy tracker
package row_policy_tracker_pkg;

  // Page policy select; encoding 3 is folded onto POL_OPEN when latched.
  typedef enum logic [1:0] {
    POL_OPEN    = 2'd0,
    POL_CLOSE   = 2'd1,
    POL_TIMEOUT = 2'd2
  } policy_t;

  // Lookup classification against the tracked open row.
  typedef enum logic [1:0] {
    RESP_HIT      = 2'd0,
    RESP_EMPTY    = 2'd1,
    RESP_CONFLICT = 2'd2
  } resp_t;

  // Commands observed from the scheduler.
  typedef enum logic [2:0] {
    CMD_ACT  = 3'd0,
    CMD_RD   = 3'd1,
    CMD_WR   = 3'd2,
    CMD_PRE  = 3'd3,
    CMD_PREA = 3'd4,
    CMD_REF  = 3'd5
  } cmd_t;

  // Number of tracked banks for a given bank-group / bank split.
  function automatic int nbank(input int bg_bits, input int ba_bits);
    return 1 << (bg_bits + ba_bits);
  endfunction

endpackage

// File: rtl/row_policy_tracker_if.sv
// rtl/row_policy_tracker_if.sv - lookup, response, command and precharge-request signals
interface row_policy_tracker_if
  import row_policy_tracker_pkg::*;
#(
  parameter int BG_BITS  = 2,
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 16
) ();
  localparam int BANK_BITS = BG_BITS + BA_BITS;

  logic                 req_valid;
  logic                 req_ready;
  logic [BANK_BITS-1:0] req_bank;
  logic [ROW_BITS-1:0]  req_row;

  logic                 resp_valid;
  logic                 resp_ready;
  resp_t                resp_type;
  logic [BANK_BITS-1:0] resp_bank;

  logic                 cmd_valid;
  cmd_t                 cmd_type;
  logic [BANK_BITS-1:0] cmd_bank;
  logic [ROW_BITS-1:0]  cmd_row;

  logic                 pre_req_valid;
  logic                 pre_req_ready;
  logic [BANK_BITS-1:0] pre_req_bank;

  // Address mapper / scheduler side.
  modport master (
    output req_valid, req_bank, req_row,
    input  req_ready,
    input  resp_valid, resp_type, resp_bank,
    output resp_ready,
    output cmd_valid, cmd_type, cmd_bank, cmd_row,
    input  pre_req_valid, pre_req_bank,
    output pre_req_ready
  );

  // Tracker side.
  modport slave (
    input  req_valid, req_bank, req_row,
    output req_ready,
    output resp_valid, resp_type, resp_bank,
    input  resp_ready,
    input  cmd_valid, cmd_type, cmd_bank, cmd_row,
    output pre_req_valid, pre_req_bank,
    input  pre_req_ready
  );

endinterface

// File: rtl/row_policy_tracker_rr_arbiter.sv
// rtl/row_policy_tracker_rr_arbiter.sv - round-robin one-hot arbiter, pointer moves past each accepted grant
module row_policy_tracker_rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] win_idx;
  logic          found;

  // Scan from the pointer upward (wrapping) and pick the first requester.
  always_comb begin
    idx     = '0;
    win_idx = '0;
    found   = 1'b0;
    grant   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  // Next search starts just after the bank that was taken.
  always_ff @(posedge clk) begin
    if (rst)                 ptr <= '0;
    else if (accept && found) ptr <= win_idx + IW'(1);
  end

endmodule

// File: rtl/row_policy_tracker.sv
// rtl/row_policy_tracker.sv - per-bank row-buffer tracker with HIT/EMPTY/CONFLICT lookup and auto-precharge
module row_policy_tracker
  import row_policy_tracker_pkg::*;
#(
  parameter int BG_BITS  = 2,
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 16,
  parameter int TIMEOUT  = 64,
  parameter int CNT_BITS = $clog2(TIMEOUT + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] pol_mode,
  row_policy_tracker_if.slave bus
);
  localparam int BANK_BITS = BG_BITS + BA_BITS;
  localparam int NBANK     = nbank(BG_BITS, BA_BITS);
  localparam logic [CNT_BITS-1:0] IDLE_MAX = CNT_BITS'(TIMEOUT);

  policy_t mode_q;
  logic    ready_en_q;

  logic [NBANK-1:0]    open_q, open_d;
  logic [NBANK-1:0]    exp_q, exp_d;
  logic [NBANK-1:0]    granted_q, granted_d;
  logic [NBANK-1:0]    kill_now;
  logic [ROW_BITS-1:0] row_q  [NBANK];
  logic [ROW_BITS-1:0] row_d  [NBANK];
  logic [CNT_BITS-1:0] idle_q [NBANK];
  logic [CNT_BITS-1:0] idle_d [NBANK];

  logic                 cmd_all_clr;
  resp_t                cls;
  logic                 resp_valid_q;
  resp_t                resp_type_q;
  logic [BANK_BITS-1:0] resp_bank_q;

  logic [NBANK-1:0]     arb_req, arb_grant;
  logic                 arb_accept;
  logic [BANK_BITS-1:0] grant_bank;
  logic                 pre_valid_q;
  logic [BANK_BITS-1:0] pre_bank_q;

  assign cmd_all_clr = bus.cmd_valid && (bus.cmd_type == CMD_PREA || bus.cmd_type == CMD_REF);

  // Latch the policy; encoding 3 behaves as OPEN and changes apply one cycle late.
  always_ff @(posedge CLK) begin
    if (RST)                     mode_q <= POL_OPEN;
    else if (pol_mode == 2'd3)   mode_q <= POL_OPEN;
    else                         mode_q <= policy_t'(pol_mode);
  end

  // Hold off lookups for the first cycle after reset is released.
  always_ff @(posedge CLK) begin
    if (RST) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // Per-bank next state: commands first, then idle ageing for untouched open banks.
  always_comb begin
    open_d    = open_q;
    exp_d     = exp_q;
    granted_d = granted_q;
    kill_now  = '0;
    for (int b = 0; b < NBANK; b++) begin
      row_d[b]  = row_q[b];
      idle_d[b] = idle_q[b];
    end
    for (int b = 0; b < NBANK; b++) begin
      if (cmd_all_clr) begin
        open_d[b]    = 1'b0;
        exp_d[b]     = 1'b0;
        granted_d[b] = 1'b0;
        kill_now[b]  = 1'b1;
      end else if (bus.cmd_valid && bus.cmd_bank == BANK_BITS'(b) && bus.cmd_type == CMD_ACT) begin
        open_d[b]    = 1'b1;
        row_d[b]     = bus.cmd_row;
        idle_d[b]    = '0;
        exp_d[b]     = 1'b0;
        granted_d[b] = 1'b0;
      end else if (bus.cmd_valid && bus.cmd_bank == BANK_BITS'(b) && bus.cmd_type == CMD_PRE) begin
        open_d[b]    = 1'b0;
        exp_d[b]     = 1'b0;
        granted_d[b] = 1'b0;
        kill_now[b]  = 1'b1;
      end else if (bus.cmd_valid && bus.cmd_bank == BANK_BITS'(b) && open_q[b] &&
                   (bus.cmd_type == CMD_RD || bus.cmd_type == CMD_WR)) begin
        // An access resets ageing and so always beats a same-cycle timeout.
        idle_d[b] = '0;
        if (mode_q == POL_CLOSE) exp_d[b] = 1'b1;
      end else if (open_q[b]) begin
        if (idle_q[b] != IDLE_MAX) idle_d[b] = idle_q[b] + CNT_BITS'(1);
        if (mode_q == POL_TIMEOUT && idle_d[b] == IDLE_MAX) exp_d[b] = 1'b1;
      end
      if (mode_q == POL_OPEN) exp_d[b] = 1'b0;
    end
    // A bank whose precharge request was taken stays parked until reopened or closed.
    if (pre_valid_q && bus.pre_req_ready && exp_d[pre_bank_q]) granted_d[pre_bank_q] = 1'b1;
  end

  // Bank state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      open_q    <= '0;
      exp_q     <= '0;
      granted_q <= '0;
      for (int b = 0; b < NBANK; b++) begin
        row_q[b]  <= '0;
        idle_q[b] <= '0;
      end
    end else begin
      open_q    <= open_d;
      exp_q     <= exp_d;
      granted_q <= granted_d;
      for (int b = 0; b < NBANK; b++) begin
        row_q[b]  <= row_d[b];
        idle_q[b] <= idle_d[b];
      end
    end
  end

  // Classify against post-command state so same-cycle ACT/PRE are visible.
  always_comb begin
    if (!open_d[bus.req_bank])                 cls = RESP_EMPTY;
    else if (row_d[bus.req_bank] == bus.req_row) cls = RESP_HIT;
    else                                        cls = RESP_CONFLICT;
  end

  assign bus.req_ready = ready_en_q && (!resp_valid_q || bus.resp_ready);

  // Single-entry response register, held while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid_q <= 1'b0;
      resp_type_q  <= RESP_HIT;
      resp_bank_q  <= '0;
    end else if (bus.req_valid && bus.req_ready) begin
      resp_valid_q <= 1'b1;
      resp_type_q  <= cls;
      resp_bank_q  <= bus.req_bank;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_type  = resp_type_q;
  assign bus.resp_bank  = resp_bank_q;

  // Only banks that stay expired through this cycle and are not parked may be offered.
  assign arb_req    = exp_q & exp_d & ~granted_q;
  assign arb_accept = !pre_valid_q && (|arb_grant);

  row_policy_tracker_rr_arbiter #(.N(NBANK)) u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    (arb_req),
    .accept (arb_accept),
    .grant  (arb_grant)
  );

  // One-hot grant to bank number.
  always_comb begin
    grant_bank = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (arb_grant[b]) grant_bank = BANK_BITS'(b);
    end
  end

  // Precharge request register: load when empty, drop on accept or when the bank is closed under it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_valid_q <= 1'b0;
      pre_bank_q  <= '0;
    end else if (pre_valid_q) begin
      if (bus.pre_req_ready || kill_now[pre_bank_q]) pre_valid_q <= 1'b0;
    end else if (arb_accept) begin
      pre_valid_q <= 1'b1;
      pre_bank_q  <= grant_bank;
    end
  end

  assign bus.pre_req_valid = pre_valid_q;
  assign bus.pre_req_bank  = pre_bank_q;

endmodule

// File: tb/tb_row_policy_tracker.sv
// tb/tb_row_policy_tracker.sv - self-checking bench for row_policy_tracker
module tb_row_policy_tracker;
  import row_policy_tracker_pkg::*;

  localparam int BG = 2;
  localparam int BA = 2;
  localparam int RB = 16;
  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] pol_mode;
  int checks   = 0;
  int failures = 0;

  row_policy_tracker_if #(.BG_BITS(BG), .BA_BITS(BA), .ROW_BITS(RB)) bus ();

  row_policy_tracker #(.BG_BITS(BG), .BA_BITS(BA), .ROW_BITS(RB), .TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .pol_mode (pol_mode),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.req_valid     = 1'b0;
    bus.req_bank      = '0;
    bus.req_row       = '0;
    bus.resp_ready    = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_type      = CMD_RD;
    bus.cmd_bank      = '0;
    bus.cmd_row       = '0;
    bus.pre_req_ready = 1'b0;
  endtask

  task automatic issue_cmd(input cmd_t t, input logic [3:0] b, input logic [15:0] r);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_bank  = b;
    bus.cmd_row   = r;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] b, input logic [15:0] r);
    bus.req_valid = 1'b1;
    bus.req_bank  = b;
    bus.req_row   = r;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %0d want 0", bus.resp_valid); end
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL rst_pre_valid: got %0d want 0", bus.pre_req_valid); end
    checks++; if (bus.resp_type !== RESP_HIT || bus.resp_bank !== 4'd0) begin failures++; $display("FAIL rst_resp_fields: got type %0d bank %0d want 0 0", bus.resp_type, bus.resp_bank); end
    checks++; if (bus.pre_req_bank !== 4'd0) begin failures++; $display("FAIL rst_pre_bank: got %0d want 0", bus.pre_req_bank); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready_low: got %0d want 0", bus.req_ready); end
    RST = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready_up: got %0d want 1", bus.req_ready); end
    lookup(4'd3, 16'h0010);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_type !== RESP_EMPTY || bus.resp_bank !== 4'd3) begin
      failures++; $display("FAIL rst_lookup: got v%0d t%0d b%0d want v1 t%0d b3", bus.resp_valid, bus.resp_type, bus.resp_bank, RESP_EMPTY);
    end
    bus.resp_ready = 1'b0;
    RST = 1'b1;
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_drop_resp: got %0d want 0", bus.resp_valid); end
    RST = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_hit_conflict();
    issue_cmd(CMD_ACT, 4'd5, 16'h1234);
    lookup(4'd5, 16'h1234);
    checks++; if (bus.resp_type !== RESP_HIT || bus.resp_bank !== 4'd5) begin failures++; $display("FAIL hc_hit: got t%0d b%0d want t%0d b5", bus.resp_type, bus.resp_bank, RESP_HIT); end
    lookup(4'd5, 16'h1235);
    checks++; if (bus.resp_type !== RESP_CONFLICT || bus.resp_valid !== 1'b1) begin failures++; $display("FAIL hc_conflict: got t%0d v%0d want t%0d v1", bus.resp_type, bus.resp_valid, RESP_CONFLICT); end
    issue_cmd(CMD_PRE, 4'd5, 16'h0);
    lookup(4'd5, 16'h1234);
    checks++; if (bus.resp_type !== RESP_EMPTY) begin failures++; $display("FAIL hc_after_pre: got %0d want %0d", bus.resp_type, RESP_EMPTY); end
    tick();
  endtask

  task automatic test_timeout();
    pol_mode = 2'd2;
    tick();
    issue_cmd(CMD_ACT, 4'd2, 16'h0042);
    for (int i = 0; i < TO; i++) tick();
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL to_early: got %0d want 0", bus.pre_req_valid); end
    tick();
    checks++; if (bus.pre_req_valid !== 1'b1 || bus.pre_req_bank !== 4'd2) begin failures++; $display("FAIL to_raise: got v%0d b%0d want v1 b2", bus.pre_req_valid, bus.pre_req_bank); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pre_req_valid !== 1'b1 || bus.pre_req_bank !== 4'd2) begin failures++; $display("FAIL to_hold: got v%0d b%0d want v1 b2", bus.pre_req_valid, bus.pre_req_bank); end
    end
    bus.pre_req_ready = 1'b1;
    tick();
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL to_accept: got %0d want 0", bus.pre_req_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL to_no_reoffer: got %0d want 0", bus.pre_req_valid); end
    end
    bus.pre_req_ready = 1'b0;
    issue_cmd(CMD_PRE, 4'd2, 16'h0);
    lookup(4'd2, 16'h0042);
    checks++; if (bus.resp_type !== RESP_EMPTY || bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL to_closed: got t%0d pv%0d want t%0d pv0", bus.resp_type, bus.pre_req_valid, RESP_EMPTY); end
    tick();
  endtask

  task automatic test_round_robin();
    pol_mode = 2'd1;
    tick();
    issue_cmd(CMD_ACT, 4'd1, 16'h0011);
    issue_cmd(CMD_ACT, 4'd6, 16'h0066);
    issue_cmd(CMD_RD, 4'd1, 16'h0);
    issue_cmd(CMD_RD, 4'd6, 16'h0);
    checks++; if (bus.pre_req_valid !== 1'b1 || bus.pre_req_bank !== 4'd1) begin failures++; $display("FAIL rr_first: got v%0d b%0d want v1 b1", bus.pre_req_valid, bus.pre_req_bank); end
    bus.pre_req_ready = 1'b1;
    tick();
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL rr_accept1: got %0d want 0", bus.pre_req_valid); end
    tick();
    checks++; if (bus.pre_req_valid !== 1'b1 || bus.pre_req_bank !== 4'd6) begin failures++; $display("FAIL rr_second: got v%0d b%0d want v1 b6", bus.pre_req_valid, bus.pre_req_bank); end
    tick();
    tick();
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL rr_drained: got %0d want 0", bus.pre_req_valid); end
    bus.pre_req_ready = 1'b0;
    pol_mode = 2'd0;
    tick();
    issue_cmd(CMD_RD, 4'd1, 16'h0);
    issue_cmd(CMD_WR, 4'd6, 16'h0);
    for (int i = 0; i < 2 * TO + 2; i++) begin
      tick();
      checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL rr_open_mode: cycle %0d got %0d want 0", i, bus.pre_req_valid); end
    end
    issue_cmd(CMD_PREA, 4'd0, 16'h0);
  endtask

  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1; bus.cmd_type = CMD_ACT; bus.cmd_bank = 4'd0; bus.cmd_row = 16'd7;
    bus.req_valid = 1'b1; bus.req_bank = 4'd0; bus.req_row = 16'd7;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_type !== RESP_HIT || bus.resp_bank !== 4'd0) begin
      failures++; $display("FAIL b2b_fwd_hit: got v%0d t%0d b%0d want v1 t%0d b0", bus.resp_valid, bus.resp_type, bus.resp_bank, RESP_HIT);
    end
    bus.resp_ready = 1'b0;
    bus.req_row    = 16'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready: cycle %0d got %0d want 0", i, bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_type !== RESP_HIT || bus.resp_bank !== 4'd0) begin
        failures++; $display("FAIL b2b_stall_hold: cycle %0d got v%0d t%0d b%0d want v1 t%0d b0", i, bus.resp_valid, bus.resp_type, bus.resp_bank, RESP_HIT);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_type !== RESP_CONFLICT) begin failures++; $display("FAIL b2b_release: got v%0d t%0d want v1 t%0d", bus.resp_valid, bus.resp_type, RESP_CONFLICT); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %0d want 0", bus.resp_valid); end
  endtask

  task automatic test_prea();
    int waited;
    issue_cmd(CMD_PRE, 4'd0, 16'h0);
    pol_mode = 2'd2;
    tick();
    issue_cmd(CMD_ACT, 4'd8, 16'h0080);
    issue_cmd(CMD_ACT, 4'd9, 16'h0090);
    issue_cmd(CMD_ACT, 4'd10, 16'h00a0);
    waited = 0;
    while (!bus.pre_req_valid && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (bus.pre_req_valid !== 1'b1 || bus.pre_req_bank !== 4'd8) begin failures++; $display("FAIL prea_pending: got v%0d b%0d want v1 b8", bus.pre_req_valid, bus.pre_req_bank); end
    issue_cmd(CMD_PREA, 4'd0, 16'h0);
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL prea_withdraw: got %0d want 0", bus.pre_req_valid); end
    for (int b = 8; b <= 10; b++) begin
      lookup(4'(b), 16'(b * 16));
      checks++; if (bus.resp_type !== RESP_EMPTY || bus.resp_bank !== 4'(b)) begin failures++; $display("FAIL prea_empty: bank %0d got t%0d b%0d want t%0d", b, bus.resp_type, bus.resp_bank, RESP_EMPTY); end
    end
    for (int i = 0; i < TO + 2; i++) tick();
    checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL prea_quiet: got %0d want 0", bus.pre_req_valid); end
    pol_mode = 2'd0;
    tick();
  endtask

  task automatic test_random();
    bit          m_open [16];
    logic [15:0] m_row  [16];
    bit          exp_valid;
    resp_t       exp_type;
    logic [3:0]  exp_bank;
    bit          exp_ready;
    int          r;
    logic [3:0]  cb;
    logic [15:0] cr;
    issue_cmd(CMD_PREA, 4'd0, 16'h0);
    tick();
    for (int b = 0; b < 16; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = '0;
    end
    exp_valid = 1'b0;
    exp_type  = RESP_HIT;
    exp_bank  = '0;
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 15));
      cb = 4'($urandom_range(0, 15));
      cr = 16'($urandom_range(0, 3));
      bus.cmd_valid = (r <= 10);
      case (r)
        0, 1, 2, 3: bus.cmd_type = CMD_ACT;
        4, 5:       bus.cmd_type = CMD_RD;
        6:          bus.cmd_type = CMD_WR;
        7, 8:       bus.cmd_type = CMD_PRE;
        9:          bus.cmd_type = CMD_PREA;
        default:    bus.cmd_type = CMD_REF;
      endcase
      bus.cmd_bank   = cb;
      bus.cmd_row    = cr;
      bus.req_valid  = ($urandom_range(0, 1) == 1);
      bus.req_bank   = 4'($urandom_range(0, 15));
      bus.req_row    = 16'($urandom_range(0, 3));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      pol_mode       = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
      #1;
      exp_ready = !exp_valid || bus.resp_ready;
      checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready: step %0d got %0d want %0d", n, bus.req_ready, exp_ready); end
      if (bus.cmd_valid) begin
        if (bus.cmd_type == CMD_ACT) begin
          m_open[cb] = 1'b1;
          m_row[cb]  = cr;
        end else if (bus.cmd_type == CMD_PRE) begin
          m_open[cb] = 1'b0;
        end else if (bus.cmd_type == CMD_PREA || bus.cmd_type == CMD_REF) begin
          for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
        end
      end
      if (bus.req_valid && exp_ready) begin
        exp_valid = 1'b1;
        exp_bank  = bus.req_bank;
        if (!m_open[bus.req_bank])                  exp_type = RESP_EMPTY;
        else if (m_row[bus.req_bank] == bus.req_row) exp_type = RESP_HIT;
        else                                         exp_type = RESP_CONFLICT;
      end else if (bus.resp_ready) begin
        exp_valid = 1'b0;
      end
      tick();
      checks++; if (bus.resp_valid !== exp_valid) begin failures++; $display("FAIL rnd_resp_valid: step %0d got %0d want %0d", n, bus.resp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.resp_type !== exp_type || bus.resp_bank !== exp_bank) begin
          failures++; $display("FAIL rnd_resp: step %0d got t%0d b%0d want t%0d b%0d", n, bus.resp_type, bus.resp_bank, exp_type, exp_bank);
        end
      end
      checks++; if (bus.pre_req_valid !== 1'b0) begin failures++; $display("FAIL rnd_open_no_pre: step %0d got %0d want 0", n, bus.pre_req_valid); end
    end
    quiet_inputs();
    pol_mode = 2'd0;
    tick();
  endtask

  initial begin
    quiet_inputs();
    pol_mode = 2'd0;
    RST      = 1'b1;
    test_reset();
    test_hit_conflict();
    test_timeout();
    test_round_robin();
    test_back_to_back();
    test_prea();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
